// File: rtl/csa_key_sched_ctrl_if.sv
// Control-word / round-key bus of csa_key_sched_ctrl.
// master = loader + datapath side, slave = key-schedule controller.
interface csa_key_sched_ctrl_if;
  logic         i_ck_valid;
  logic         o_ck_ready;
  logic [63:0]  i_ck;
  logic         i_ck_odd;
  logic         i_sel_odd;
  logic [447:0] o_kk;
  logic         o_kk_valid;
  logic         o_busy;
  logic         o_done;

  modport master (
    output i_ck_valid, i_ck, i_ck_odd, i_sel_odd,
    input  o_ck_ready, o_kk, o_kk_valid, o_busy, o_done
  );

  modport slave (
    input  i_ck_valid, i_ck, i_ck_odd, i_sel_odd,
    output o_ck_ready, o_kk, o_kk_valid, o_busy, o_done
  );
endinterface

// File: rtl/csa_key_sched_ctrl.sv
// Iterative CSA key-schedule controller: 7 key_perm rounds into a staging vector, atomic bank commit.
// Define CSA_KEY_SCHED_DUAL_BANK_EN for even/odd banks; otherwise a single bank is used.
module csa_key_sched_ctrl (
  input logic                 i_clk,
  input logic                 i_rst,
  csa_key_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PERM   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Destination (1-based) of key bit i, bits numbered MSB-first as in the CSA reference
  localparam logic [6:0] KEY_PERM [64] = '{
    7'd18, 7'd36, 7'd9,  7'd7,  7'd42, 7'd49, 7'd29, 7'd21,
    7'd28, 7'd54, 7'd62, 7'd50, 7'd19, 7'd33, 7'd59, 7'd64,
    7'd24, 7'd20, 7'd37, 7'd39, 7'd2,  7'd53, 7'd27, 7'd1,
    7'd34, 7'd4,  7'd13, 7'd14, 7'd57, 7'd40, 7'd26, 7'd41,
    7'd51, 7'd35, 7'd52, 7'd12, 7'd22, 7'd48, 7'd30, 7'd58,
    7'd45, 7'd31, 7'd8,  7'd25, 7'd23, 7'd47, 7'd61, 7'd17,
    7'd60, 7'd5,  7'd56, 7'd43, 7'd11, 7'd6,  7'd10, 7'd44,
    7'd32, 7'd63, 7'd46, 7'd15, 7'd3,  7'd38, 7'd16, 7'd55
  };

  function automatic logic [63:0] key_perm(input logic [63:0] k);
    logic [63:0] r;
    int          j;
    r = 64'd0;
    for (int i = 0; i < 64; i++) begin
      j = int'(KEY_PERM[i]) - 1;
      r[63 - j] = k[63 - i];
    end
    return r;
  endfunction

  state_t       state_r;
  logic [63:0]  work_r;
  logic [447:0] staging_r;
  logic [7:0]   rnd_r;
  logic         done_r;
  logic [63:0]  perm_s;

`ifdef CSA_KEY_SCHED_DUAL_BANK_EN
  logic         tgt_r;
  logic [447:0] bank_r [2];
  logic [1:0]   valid_r;
`else
  logic [447:0] bank_r;
  logic         valid_r;
`endif

  assign perm_s = key_perm(work_r);

  // Sequencer: handshake, 7 permutation rounds, atomic bank commit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      work_r    <= 64'd0;
      staging_r <= 448'd0;
      rnd_r     <= 8'd0;
      done_r    <= 1'b0;
`ifdef CSA_KEY_SCHED_DUAL_BANK_EN
      tgt_r     <= 1'b0;
      bank_r[0] <= 448'd0;
      bank_r[1] <= 448'd0;
      valid_r   <= 2'b00;
`else
      bank_r    <= 448'd0;
      valid_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.i_ck_valid) begin
            work_r  <= bus.i_ck;
            rnd_r   <= 8'd6;
            state_r <= PERM;
`ifdef CSA_KEY_SCHED_DUAL_BANK_EN
            tgt_r   <= bus.i_ck_odd;
`endif
          end
        end
        PERM: begin
          work_r <= perm_s;
          for (int s = 0; s < 7; s++) begin
            if (rnd_r == 8'(s)) begin
              staging_r[s*64 +: 64] <= perm_s ^ {8{rnd_r}};
            end
          end
          if (rnd_r == 8'd0) begin
            state_r <= COMMIT;
          end else begin
            rnd_r <= rnd_r - 8'd1;
          end
        end
        COMMIT: begin
`ifdef CSA_KEY_SCHED_DUAL_BANK_EN
          bank_r[tgt_r]  <= staging_r;
          valid_r[tgt_r] <= 1'b1;
`else
          bank_r  <= staging_r;
          valid_r <= 1'b1;
`endif
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ck_ready = (state_r == IDLE);
  assign bus.o_busy     = (state_r == PERM) || (state_r == COMMIT);
  assign bus.o_done     = done_r;

  // Bank read mux straight from registers; never touches the incoming control word
`ifdef CSA_KEY_SCHED_DUAL_BANK_EN
  assign bus.o_kk       = bank_r[bus.i_sel_odd];
  assign bus.o_kk_valid = valid_r[bus.i_sel_odd];
`else
  assign bus.o_kk       = bank_r;
  assign bus.o_kk_valid = valid_r;
`endif

endmodule
